// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory interface.
// Lane/byte-enable rules used by lsu_mem_if and lsu_lane_align.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        ERR
    } state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        case (size)
            SZ_B:    byte_en = 4'b0001 << off;
            SZ_H:    byte_en = off[1] ? 4'b1100 : 4'b0011;
            default: byte_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / replicated data
// and load data right-shift into the low lanes.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    always_comb begin
        be_o = byte_en(st_size_i, st_off_i);

        case (st_size_i)
            SZ_B:    wdata_o = {4{wdata_i[7:0]}};
            SZ_H:    wdata_o = {2{wdata_i[15:0]}};
            default: wdata_o = wdata_i;
        endcase

        case (ld_size_i)
            SZ_B:    rdata_o = rdata_i >> {ld_off_i, 3'b000};
            SZ_H:    rdata_o = rdata_i >> {ld_off_i[1], 4'b0000};
            default: rdata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// LSU req/ack bus stage with timeout; LSU_MISALIGN_TRAP_EN rejects
// misaligned half/word accesses instead of forcing them aligned.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_aligned,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         size_q;
    logic [1:0]         off_q;
    logic               done_q;
    logic               mis_q;
    logic               err_q;
    logic               req_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;

    logic [1:0]         req_size;
    logic               mis_req;
    logic [3:0]         be_d;
    logic [31:0]        wdata_d;
    logic [31:0]        rdata_d;
    logic               unused_f3;

    // funct3[2] only selects sign/zero extension downstream
    assign unused_f3 = funct3[2];
    assign req_size  = (funct3[1:0] == 2'b11) ? SZ_W : funct3[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_req = ((req_size == SZ_H) && addr[0]) ||
                     ((req_size == SZ_W) && (addr[1:0] != 2'b00));
`else
    assign mis_req = 1'b0;
`endif

    lsu_lane_align u_align (
        .st_size_i (req_size),
        .st_off_i  (addr[1:0]),
        .wdata_i   (wdata),
        .ld_size_i (size_q),
        .ld_off_i  (off_q),
        .rdata_i   (bus_rdata),
        .be_o      (be_d),
        .wdata_o   (wdata_d),
        .rdata_o   (rdata_d)
    );

    assign busy = ((state_q == IDLE) && req_valid) || (state_q == REQ);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= SZ_B;
            off_q   <= 2'b00;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            mis_q  <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= {addr[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        we_q    <= req_write;
                        size_q  <= req_size;
                        off_q   <= addr[1:0];
                        cnt_q   <= '0;
                        if (mis_req) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            mis_q   <= 1'b1;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // ack takes priority over the terminal count
                    if (bus_ack) begin
                        state_q <= DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        if (!we_q) begin
                            rdata_q <= rdata_d;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_q <= ERR;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done          = done_q;
    assign misalign      = mis_q;
    assign bus_err       = err_q;
    assign bus_req       = req_q;
    assign bus_we        = we_q;
    assign bus_addr      = addr_q;
    assign bus_be        = be_q;
    assign bus_wdata     = wdata_q;
    assign rdata_aligned = rdata_q;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Self-checking bench for lsu_mem_if against a transaction-level model.
// Honours LSU_MISALIGN_TRAP_EN the same way as the design.
module tb_lsu_mem_if;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata_aligned;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    int total = 0;
    int bad   = 0;
    bit trap_en;
    logic [31:0] last_rdata;

    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_be;
    logic        r_we, r_err, r_mis, r_bad_busy, r_bad_stable;
    int          r_nreq, r_done;

    always #5 clk = ~clk;

    lsu_mem_if #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .funct3        (funct3),
        .addr          (addr),
        .wdata         (wdata),
        .busy          (busy),
        .done          (done),
        .rdata_aligned (rdata_aligned),
        .misalign      (misalign),
        .bus_err       (bus_err),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_be        (bus_be),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_ack       (bus_ack)
    );

    // Reference rules, written from the lane/size table
    function automatic int m_size(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) ? 2 : int'(f3[1:0]);
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int off = int'(a[1:0]);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return (off >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 1) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input logic [31:0] a, input logic [31:0] d);
        int off = int'(a[1:0]);
        if (sz == 0) return d >> (8 * off);
        if (sz == 1) return d >> (16 * (off / 2));
        return d;
    endfunction

    function automatic bit m_mis(input int sz, input logic [31:0] a);
        if (!trap_en) return 1'b0;
        if (sz == 1) return a[0];
        if (sz == 2) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic int m_nreq(input bit mis, input int dly);
        if (mis) return 0;
        return (dly >= TO) ? TO : dly + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one access and records what the bus side showed
    task automatic run_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int dly);
        int cyc;
        r_nreq = 0; r_done = 0; r_err = 0; r_mis = 0;
        r_bad_busy = 0; r_bad_stable = 0;
        r_addr = '0; r_be = '0; r_wdata = '0; r_we = 0; r_rdata = '0;
        req_valid = 1'b1; req_write = w; funct3 = f3; addr = a; wdata = wd;
        bus_rdata = rd; bus_ack = 1'b0;
        #1;
        if (busy !== 1'b1) r_bad_busy = 1;
        tick();
        req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
        cyc = 2;
        while (cyc < 60 && r_done == 0) begin
            if (done === 1'b1) begin
                r_done = cyc; r_err = bus_err; r_mis = misalign; r_rdata = rdata_aligned;
                if (busy !== 1'b0) r_bad_busy = 1;
                bus_ack = 1'b0;
            end else begin
                if (bus_req === 1'b1) begin
                    if (r_nreq == 0) begin
                        r_addr = bus_addr; r_be = bus_be; r_wdata = bus_wdata; r_we = bus_we;
                    end else if (r_addr !== bus_addr || r_be !== bus_be ||
                                 r_wdata !== bus_wdata || r_we !== bus_we) begin
                        r_bad_stable = 1;
                    end
                    if (busy !== 1'b1) r_bad_busy = 1;
                    bus_ack = (r_nreq == dly);
                    r_nreq++;
                end else begin
                    bus_ack = 1'b0;
                end
                tick();
                cyc++;
            end
        end
        bus_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 0; req_write = 0; funct3 = 0; addr = 0; wdata = 0;
        bus_rdata = 0; bus_ack = 0;
        repeat (3) tick();
        total++;
        if ({busy, done, misalign, bus_err, bus_req, bus_we} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=000000", {busy, done, misalign, bus_err, bus_req, bus_we});
        end
        total++;
        if (bus_addr !== 0 || bus_be !== 0 || bus_wdata !== 0 || rdata_aligned !== 0) begin
            bad++;
            $display("FAIL reset_data addr=%h be=%h wd=%h rd=%h want all zero",
                     bus_addr, bus_be, bus_wdata, rdata_aligned);
        end
        rst_n = 1'b1;
        tick();
        last_rdata = '0;
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 3'b100, 32'h1003, 32'h5555_5555, 32'hAABB_CCDD, 0);
        last_rdata = 32'h0000_00AA;
        total++;
        if (r_addr !== 32'h1000 || r_be !== 4'b1000 || r_we !== 1'b0) begin
            bad++;
            $display("FAIL lb_bus addr=%h be=%b we=%b want 00001000/1000/0", r_addr, r_be, r_we);
        end
        total++;
        if (r_rdata !== last_rdata) begin
            bad++;
            $display("FAIL lb_rdata got=%h want=%h", r_rdata, last_rdata);
        end
        total++;
        if (r_done !== 3 || r_nreq !== 1 || r_bad_busy) begin
            bad++;
            $display("FAIL lb_timing done_cyc=%0d nreq=%0d busy_bad=%0d want 3/1/0", r_done, r_nreq, r_bad_busy);
        end
    endtask

    task automatic test_store_half();
        run_access(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 1);
        total++;
        if (r_we !== 1'b1 || r_be !== 4'b1100 || r_wdata !== 32'hBEEF_BEEF || r_addr !== 32'h2000) begin
            bad++;
            $display("FAIL sh_bus we=%b be=%b wd=%h addr=%h want 1/1100/beefbeef/00002000",
                     r_we, r_be, r_wdata, r_addr);
        end
        total++;
        if (r_bad_busy || r_done !== 4 || r_rdata !== last_rdata) begin
            bad++;
            $display("FAIL sh_done busy_bad=%0d done_cyc=%0d rd=%h want 0/4/%h",
                     r_bad_busy, r_done, r_rdata, last_rdata);
        end
    endtask

    task automatic test_delayed_word();
        run_access(1'b0, 3'b010, 32'h4008, 32'h0, 32'hCAFE_F00D, 4);
        last_rdata = 32'hCAFE_F00D;
        total++;
        if (r_nreq !== 5 || r_bad_stable || r_bad_busy) begin
            bad++;
            $display("FAIL lw_hold nreq=%0d unstable=%0d busy_bad=%0d want 5/0/0",
                     r_nreq, r_bad_stable, r_bad_busy);
        end
        total++;
        if (r_done !== 7 || r_rdata !== last_rdata || r_be !== 4'hF) begin
            bad++;
            $display("FAIL lw_done done_cyc=%0d rd=%h be=%h want 7/%h/f", r_done, r_rdata, r_be, last_rdata);
        end
    endtask

    task automatic test_timeout();
        run_access(1'b0, 3'b010, 32'h5000, 32'h0, 32'h0BAD_0BAD, 1000);
        total++;
        if (r_err !== 1'b1 || r_nreq !== TO || r_done !== TO + 2) begin
            bad++;
            $display("FAIL to_err err=%b nreq=%0d done_cyc=%0d want 1/%0d/%0d",
                     r_err, r_nreq, r_done, TO, TO + 2);
        end
        total++;
        if (r_rdata !== last_rdata || bus_req !== 1'b0) begin
            bad++;
            $display("FAIL to_hold rd=%h req=%b want %h/0", r_rdata, bus_req, last_rdata);
        end
        run_access(1'b0, 3'b010, 32'h5004, 32'h0, 32'h7777_1111, TO - 1);
        last_rdata = 32'h7777_1111;
        total++;
        if (r_err !== 1'b0 || r_done !== TO + 2 || r_rdata !== last_rdata) begin
            bad++;
            $display("FAIL to_ackwins err=%b done_cyc=%0d rd=%h want 0/%0d/%h",
                     r_err, r_done, r_rdata, TO + 2, last_rdata);
        end
    endtask

    task automatic test_misalign_half();
        run_access(1'b0, 3'b001, 32'h3001, 32'h0, 32'h1122_3344, 0);
        if (trap_en) begin
            total++;
            if (r_mis !== 1'b1 || r_nreq !== 0 || r_done !== 2 || r_rdata !== last_rdata) begin
                bad++;
                $display("FAIL mis_trap mis=%b nreq=%0d done_cyc=%0d rd=%h want 1/0/2/%h",
                         r_mis, r_nreq, r_done, r_rdata, last_rdata);
            end
        end else begin
            last_rdata = 32'h1122_3344;
            total++;
            if (r_mis !== 1'b0 || r_be !== 4'b0011 || r_done !== 3 || r_rdata !== last_rdata) begin
                bad++;
                $display("FAIL mis_pass mis=%b be=%b done_cyc=%0d rd=%h want 0/0011/3/%h",
                         r_mis, r_be, r_done, r_rdata, last_rdata);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done = 0;
        req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h6000;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre req=%b want 1", bus_req);
        end
        rst_n = 1'b0;
        tick();
        total++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid req=%b busy=%b done=%b want 0/0/0", bus_req, busy, done);
        end
        rst_n = 1'b1;
        last_rdata = '0;
        repeat (3) begin
            tick();
            if (done === 1'b1) saw_done = 1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL rst_nodone got=1 want=0");
        end
        run_access(1'b0, 3'b101, 32'h6002, 32'h0, 32'h89AB_CDEF, 2);
        last_rdata = 32'h0000_89AB;
        total++;
        if (r_done !== 5 || r_rdata !== last_rdata || r_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_after done_cyc=%0d rd=%h err=%b want 5/%h/0",
                     r_done, r_rdata, r_err, last_rdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic        w  = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a  = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            int dly = ($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(0, 5));
            int sz = m_size(f3);
            bit mis = m_mis(sz, a);
            int nreq = m_nreq(mis, dly);
            bit to = !mis && dly >= TO;
            run_access(w, f3, a, wd, rd, dly);
            if (!mis && !to && !w) last_rdata = m_load(sz, a, rd);
            total++;
            if (r_done !== 2 + nreq || r_nreq !== nreq || r_err !== to || r_mis !== mis) begin
                bad++;
                $display("FAIL rnd_flow[%0d] done_cyc=%0d nreq=%0d err=%b mis=%b want %0d/%0d/%b/%b",
                         n, r_done, r_nreq, r_err, r_mis, 2 + nreq, nreq, to, mis);
            end
            total++;
            if (r_rdata !== last_rdata) begin
                bad++;
                $display("FAIL rnd_rdata[%0d] got=%h want=%h", n, r_rdata, last_rdata);
            end
            total++;
            if (r_bad_busy || r_bad_stable) begin
                bad++;
                $display("FAIL rnd_busy[%0d] busy_bad=%0d unstable=%0d want 0/0", n, r_bad_busy, r_bad_stable);
            end
            if (!mis) begin
                total++;
                if (r_addr !== {a[31:2], 2'b00} || r_be !== m_be(sz, a) ||
                    r_we !== w || (w && r_wdata !== m_wdata(sz, wd))) begin
                    bad++;
                    $display("FAIL rnd_bus[%0d] addr=%h be=%b we=%b wd=%h want %h/%b/%b/%h",
                             n, r_addr, r_be, r_we, r_wdata, {a[31:2], 2'b00}, m_be(sz, a), w,
                             m_wdata(sz, wd));
                end
            end
        end
    endtask

    initial begin
`ifdef LSU_MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        test_reset();
        test_load_byte();
        test_store_half();
        test_delayed_word();
        test_timeout();
        test_misalign_half();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
